remote_transmitter: RTL and testbench

- Serializes one remote-control frame onto a single-wire Serial line: start bit, 16-bit custom code, 8-bit key and 8-bit inverted key, then an idle-high gap.
- Sits at the sending end of the remote-control serial link. It is used as the stimulus source for the remote receiver and as the TX side of loopback and board tests.
- The frame format is bit-exact with the receiver: line idles high, start = one low bit, fields are sent MSB first, and the receiver samples one bit per clock when CYCLES_PER_BIT=1.

---
 rtl/remote_pkg.sv | 17 +
 rtl/remote_bit_timer.sv | 28 ++
 rtl/remote_transmitter.sv | 120 ++++++++++++
 tb/tb_remote_transmitter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/remote_pkg.sv
// Shared frame constants and transmitter state type for the remote-control serial link.
package remote_pkg;

    localparam int   CUSTOM_W   = 16;
    localparam int   KEY_W      = 8;
    localparam int   FRAME_BITS = 32;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/remote_bit_timer.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1 while enabled and flags the terminal count.
module remote_bit_timer #(
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // With one cycle per bit the counter stays at 0 and every enabled cycle ticks.
    assign bit_tick = enable && (cnt == LAST);

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/remote_transmitter.sv
// Remote-control frame serializer: start bit, {Custom, Tecla, ~Tecla} MSB first, idle-high gap, Done.
// Build option REMOTE_TX_ERR_INJECT_EN adds ErrInject, which corrupts bit 0 of the inverted-key field.
module remote_transmitter
    import remote_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 1,
    parameter int GAP_CYCLES     = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [CUSTOM_W-1:0] Custom,
    input  logic [KEY_W-1:0]    Tecla,
`ifdef REMOTE_TX_ERR_INJECT_EN
    input  logic                ErrInject,
`endif
    output logic                Serial,
    output logic                Busy,
    output logic                Done
);

    // Handshake: a request is accepted on any edge where Start=1 and Busy=0; Busy then stays
    // high for the whole frame and gap, requests seen while Busy=1 are dropped, and Done pulses
    // in the first cycle Busy is low again, so a held Start chains frames with no idle cycle.

    localparam int BW = $clog2(FRAME_BITS);
    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [KEY_W-1:0]      inv_key;
    logic                  timer_en;
    logic                  bit_tick;

`ifdef REMOTE_TX_ERR_INJECT_EN
    assign inv_key = ~Tecla ^ {{(KEY_W-1){1'b0}}, ErrInject};
`else
    assign inv_key = ~Tecla;
`endif

    assign timer_en = (state == START) || (state == DATA);

    remote_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_bit_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .enable  (timer_en),
        .clear   (!timer_en),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            Serial  <= LINE_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    Serial  <= LINE_IDLE;
                    Busy    <= 1'b0;
                    bit_cnt <= '0;
                    gap_cnt <= '0;
                    if (Start && !Busy) begin
                        shreg  <= {Custom, Tecla, inv_key};
                        Serial <= LINE_START;
                        Busy   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        Serial <= shreg[FRAME_BITS-1];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    // Serial already shows shreg[MSB]; on each tick present the next bit.
                    if (bit_tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            Serial  <= LINE_IDLE;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            shreg   <= shreg << 1;
                            Serial  <= shreg[FRAME_BITS-2];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    Serial <= LINE_IDLE;
                    if (gap_cnt == GAP_LAST) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    Serial <= LINE_IDLE;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_transmitter.sv
// Bench for remote_transmitter: two instances (1 and 3 cycles per bit) checked against a frame-level model.
module tb_remote_transmitter;

    localparam int GAP = 8;
`ifdef REMOTE_TX_ERR_INJECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  start_r;
    logic [1:0]  err_r;
    logic [15:0] custom_r [2];
    logic [7:0]  tecla_r  [2];
    logic [1:0]  serial_w;
    logic [1:0]  busy_w;
    logic [1:0]  done_w;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [0:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    remote_transmitter #(.CYCLES_PER_BIT(1), .GAP_CYCLES(GAP)) dut0 (
        .Clock (clock),
        .Reset (reset),
        .Start (start_r[0]),
        .Custom(custom_r[0]),
        .Tecla (tecla_r[0]),
`ifdef REMOTE_TX_ERR_INJECT_EN
        .ErrInject(err_r[0]),
`endif
        .Serial(serial_w[0]),
        .Busy  (busy_w[0]),
        .Done  (done_w[0])
    );

    remote_transmitter #(.CYCLES_PER_BIT(3), .GAP_CYCLES(GAP)) dut1 (
        .Clock (clock),
        .Reset (reset),
        .Start (start_r[1]),
        .Custom(custom_r[1]),
        .Tecla (tecla_r[1]),
`ifdef REMOTE_TX_ERR_INJECT_EN
        .ErrInject(err_r[1]),
`endif
        .Serial(serial_w[1]),
        .Busy  (busy_w[1]),
        .Done  (done_w[1])
    );

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line, one entry per clock: 33 bits each held cpb cycles, then GAP idle-high cycles.
    task automatic build_frame(input int cpb, input logic [15:0] c, input logic [7:0] k, input logic e);
        logic [32:0] fr;
        logic [7:0]  inv;
        inv = ~k ^ (ERR_EN ? {7'b0, e} : 8'h00);
        fr  = {1'b0, c, k, inv};
        exp_q.delete();
        for (int b = 32; b >= 0; b--)
            for (int r = 0; r < cpb; r++) exp_q.push_back(fr[b]);
        for (int g = 0; g < GAP; g++) exp_q.push_back(1'b1);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the Done cycle.
    // gi>0 pulses Start with junk data mid-frame; hold keeps Start high for a chained frame.
    task automatic tx_frame(input int sel, input logic [15:0] c, input logic [7:0] k,
                            input logic e, input int gi, input bit hold);
        int n;
        start_r[sel]  = 1'b1;
        custom_r[sel] = c;
        tecla_r[sel]  = k;
        err_r[sel]    = e;
        check_eq("busy_before_start", busy_w[sel], 0);
        build_frame(sel ? 3 : 1, c, k, e);
        n = exp_q.size();
        check_eq("frame_len", n, (sel ? 3 : 1) * 33 + GAP);
        @(posedge clock);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_eq("serial", serial_w[sel], exp_q.pop_front());
            check_eq("busy_in_frame", busy_w[sel], 1);
            check_eq("done_in_frame", done_w[sel], 0);
            if (i == 0) begin
                custom_r[sel] = 16'($urandom);
                tecla_r[sel]  = 8'($urandom);
                err_r[sel]    = 1'($urandom);
                if (!hold) start_r[sel] = 1'b0;
            end
            if (gi > 0 && i == gi)     start_r[sel] = 1'b1;
            if (gi > 0 && i == gi + 1) start_r[sel] = 1'b0;
        end
        @(negedge clock);
        check_eq("done_pulse", done_w[sel], 1);
        check_eq("busy_at_done", busy_w[sel], 0);
        check_eq("serial_at_done", serial_w[sel], 1);
    endtask

    task automatic idle(input int sel, input int n);
        start_r[sel] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_eq("idle_serial", serial_w[sel], 1);
            check_eq("idle_busy", busy_w[sel], 0);
            check_eq("idle_done", done_w[sel], 0);
        end
    endtask

    // Start a frame on dut0, check the first cut cycles, then reset and confirm the abort.
    task automatic tx_abort(input logic [15:0] c, input logic [7:0] k, input int cut);
        start_r[0]  = 1'b1;
        custom_r[0] = c;
        tecla_r[0]  = k;
        err_r[0]    = 1'b0;
        build_frame(1, c, k, 1'b0);
        @(posedge clock);
        for (int i = 0; i < cut; i++) begin
            @(negedge clock);
            if (i == 0) start_r[0] = 1'b0;
            check_eq("abort_serial", serial_w[0], exp_q.pop_front());
        end
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_serial_rst", serial_w[0], 1);
        check_eq("abort_busy_rst", busy_w[0], 0);
        check_eq("abort_done_rst", done_w[0], 0);
        reset = 1'b0;
        idle(0, 45);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        start_r = 2'b00;
        err_r   = 2'b00;
        for (int s = 0; s < 2; s++) begin
            custom_r[s] = '0;
            tecla_r[s]  = '0;
        end
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_serial", serial_w[s], 1);
            check_eq("rst_busy", busy_w[s], 0);
            check_eq("rst_done", done_w[s], 0);
        end
        reset = 1'b0;
        idle(0, 2);
        idle(1, 2);

        // Basic frame with an ignored mid-frame Start carrying other data.
        tx_frame(0, 16'hA55A, 8'h3C, 1'b0, 9, 1'b0);
        idle(0, 3);

        // Back-to-back frames with Start held high through Done.
        tx_frame(0, 16'h1234, 8'h01, 1'b0, 0, 1'b1);
        tx_frame(0, 16'h1234, 8'hFE, 1'b0, 0, 1'b0);
        idle(0, 2);

        // Reset mid-frame, then a clean frame.
        tx_abort(16'hBEEF, 8'h5A, 19);
        tx_frame(0, 16'hA55A, 8'h3C, 1'b0, 0, 1'b0);
        idle(0, 2);

        // Three cycles per bit.
        tx_frame(1, 16'hC3A5, 8'h80, 1'b0, 0, 1'b0);
        idle(1, 2);
        tx_frame(1, 16'h0001, 8'h7F, 1'b0, 40, 1'b1);
        tx_frame(1, 16'h8000, 8'h00, 1'b0, 0, 1'b0);
        idle(1, 2);

        // Error-inject field (only alters the line when the option is built in).
        tx_frame(0, 16'h0F0F, 8'h55, 1'b1, 0, 1'b0);
        idle(0, 1);
        tx_frame(0, 16'h0F0F, 8'h55, 1'b0, 0, 1'b0);
        idle(0, 1);

        // Randomized frames on either instance.
        for (int t = 0; t < 10; t++) begin
            int sel;
            int gi;
            sel = int'($urandom_range(0, 1));
            gi  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 35)) : 0;
            tx_frame(sel, 16'($urandom), 8'($urandom), 1'($urandom), gi, 1'b0);
            idle(sel, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
